// File: rtl/sys_bus_pkg.sv
// Shared types and constants for the system-bus memory responder.
// Request capture layout and FSM encoding live here.
package sys_bus_pkg;

  localparam int SYS_DW   = 64;
  localparam int SYS_AW   = 32;
  localparam int SYS_SW   = SYS_DW / 8;
  localparam int LAT_W    = 4;
  localparam int ADDR_LSB = $clog2(SYS_SW);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_e;

  typedef struct packed {
    logic [SYS_AW-1:0] addr;
    logic [SYS_DW-1:0] wdata;
    logic [SYS_SW-1:0] sel;
    logic              wen;
    logic              ren;
    logic [LAT_W-1:0]  lat;
  } sys_req_t;

endpackage

// File: rtl/sys_bus_mem_bank.sv
// Byte-enabled single-port RAM with a registered read port.
// Written so that synthesis maps it onto block RAM.
module sys_bus_mem_bank #(
  parameter int DW    = 64,
  parameter int SW    = DW / 8,
  parameter int DEPTH = 256,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [SW-1:0] sel,
  input  logic [IW-1:0] idx,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < SW; b++) begin
        if (sel[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
    rdata <= mem[idx];
  end

endmodule

// File: rtl/sys_bus_mem_responder.sv
// System-bus slave: windowed word memory with programmable ack latency,
// error responses for misses and sticky protocol-violation detection.
module sys_bus_mem_responder
  import sys_bus_pkg::*;
#(
  parameter int                AXI_DW    = SYS_DW,
  parameter int                AXI_AW    = SYS_AW,
  parameter int                AXI_SW    = AXI_DW / 8,
  parameter int                DEPTH     = 256,
  parameter logic [AXI_AW-1:0] BASE_ADDR = 32'h4000_0000
) (
  input  logic              axi_clk_i,
  input  logic              axi_rstn_i,
  input  logic [AXI_AW-1:0] sys_addr_i,
  input  logic [AXI_DW-1:0] sys_wdata_i,
  input  logic [AXI_SW-1:0] sys_sel_i,
  input  logic              sys_wen_i,
  input  logic              sys_ren_i,
  input  logic [3:0]        lat_i,
  output logic [AXI_DW-1:0] sys_rdata_o,
  output logic              sys_err_o,
  output logic              sys_ack_o,
  output logic              proto_err_o,
  output logic [15:0]       wr_cnt_o,
  output logic [15:0]       rd_cnt_o
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [AXI_AW:0] WIN = (AXI_AW+1)'(DEPTH * AXI_SW);

  state_e            state_q;
  sys_req_t          req_q;
  sys_req_t          in_req;
  sys_req_t          cur;
  logic [3:0]        cnt_q;
  logic              ack_q;
  logic              err_q;
  logic              rd_ok_q;
  logic              proto_q;
  logic [15:0]       wr_cnt_q;
  logic [15:0]       rd_cnt_q;
  logic [AXI_DW-1:0] rhold_q;

  logic              strobe;
  logic [AXI_AW-1:0] off;
  logic              hit;
  logic              ok;
  logic [IW-1:0]     idx;
  logic              go_ack;
  logic              bank_we;
  logic [AXI_DW-1:0] bank_rdata;

  assign strobe = sys_wen_i | sys_ren_i;

  always_comb begin
    in_req       = '0;
    in_req.addr  = sys_addr_i;
    in_req.wdata = sys_wdata_i;
    in_req.sel   = sys_sel_i;
    in_req.wen   = sys_wen_i;
    in_req.ren   = sys_ren_i;
    in_req.lat   = lat_i;
  end

  // In IDLE the live inputs drive the RAM so a zero-latency
  // request can commit or read on its own capture edge.
  assign cur = (state_q == IDLE) ? in_req : req_q;

  assign off     = cur.addr - BASE_ADDR;
  assign hit     = (cur.addr >= BASE_ADDR) && ({1'b0, off} < WIN);
  assign ok      = hit & ~(cur.wen & cur.ren);
  assign idx     = off[ADDR_LSB +: IW];
  assign go_ack  = ((state_q == IDLE) && strobe && (cur.lat == '0))
                || ((state_q == WAIT) && (cnt_q == 4'd1));
  assign bank_we = go_ack & ok & cur.wen;

  sys_bus_mem_bank #(
    .DW    (AXI_DW),
    .SW    (AXI_SW),
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_bank (
    .clk   (axi_clk_i),
    .we    (bank_we),
    .sel   (cur.sel),
    .idx   (idx),
    .wdata (cur.wdata),
    .rdata (bank_rdata)
  );

  always_ff @(posedge axi_clk_i or negedge axi_rstn_i) begin
    if (!axi_rstn_i) begin
      state_q  <= IDLE;
      req_q    <= '0;
      cnt_q    <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rd_ok_q  <= 1'b0;
      proto_q  <= 1'b0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      rhold_q  <= '0;
    end else begin
      ack_q   <= 1'b0;
      rd_ok_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (strobe) begin
            req_q <= in_req;
            if (sys_wen_i & sys_ren_i) proto_q <= 1'b1;
            if (lat_i == '0) begin
              state_q <= ACK;
            end else begin
              state_q <= WAIT;
              cnt_q   <= lat_i;
            end
          end
        end
        WAIT: begin
          if (strobe) proto_q <= 1'b1;
          if (cnt_q == 4'd1) state_q <= ACK;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        ACK: begin
          if (strobe) proto_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      if (go_ack) begin
        ack_q   <= 1'b1;
        err_q   <= ~ok;
        rd_ok_q <= ok & cur.ren;
        if (!ok) rhold_q <= '0;
        if (ok & cur.wen) wr_cnt_q <= wr_cnt_q + 16'd1;
        if (ok & cur.ren) rd_cnt_q <= rd_cnt_q + 16'd1;
      end

      if (ack_q && rd_ok_q) rhold_q <= bank_rdata;
    end
  end

  assign sys_ack_o   = ack_q;
  assign sys_err_o   = err_q;
  assign proto_err_o = proto_q;
  assign wr_cnt_o    = wr_cnt_q;
  assign rd_cnt_o    = rd_cnt_q;
  assign sys_rdata_o = (ack_q && rd_ok_q) ? bank_rdata : rhold_q;

endmodule

// File: tb/tb_sys_bus_mem_responder.sv
// Directed bench for sys_bus_mem_responder (64-bit, 256 words).
// Inputs change 1ns after each rising edge; outputs are sampled there too.
module tb_sys_bus_mem_responder;

  logic        clk;
  logic        rstn;
  logic [31:0] addr;
  logic [63:0] wdata;
  logic [7:0]  sel;
  logic        wen;
  logic        ren;
  logic [3:0]  lat;
  logic [63:0] rdata;
  logic        err;
  logic        ack;
  logic        proto;
  logic [15:0] wr_cnt;
  logic [15:0] rd_cnt;

  int errors = 0;
  int checks = 0;
  int n;
  int acks;
  int first;

  sys_bus_mem_responder #(
    .AXI_DW    (64),
    .AXI_AW    (32),
    .AXI_SW    (8),
    .DEPTH     (256),
    .BASE_ADDR (32'h4000_0000)
  ) dut (
    .axi_clk_i   (clk),
    .axi_rstn_i  (rstn),
    .sys_addr_i  (addr),
    .sys_wdata_i (wdata),
    .sys_sel_i   (sel),
    .sys_wen_i   (wen),
    .sys_ren_i   (ren),
    .lat_i       (lat),
    .sys_rdata_o (rdata),
    .sys_err_o   (err),
    .sys_ack_o   (ack),
    .proto_err_o (proto),
    .wr_cnt_o    (wr_cnt),
    .rd_cnt_o    (rd_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic w, input logic r, input logic [31:0] a,
                        input logic [63:0] d, input logic [7:0] s,
                        input logic [3:0] l);
    wen   = w;
    ren   = r;
    addr  = a;
    wdata = d;
    sel   = s;
    lat   = l;
    step();
    wen = 1'b0;
    ren = 1'b0;
    lat = 4'd0;
  endtask

  task automatic wait_ack(output int cyc);
    cyc = 0;
    while (!ack && cyc < 40) begin
      step();
      cyc++;
    end
  endtask

  initial begin
    rstn  = 1'b0;
    addr  = '0;
    wdata = '0;
    sel   = '0;
    wen   = 1'b0;
    ren   = 1'b0;
    lat   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_rdata", rdata, 64'd0);
    check("rst_proto", 64'(proto), 64'd0);
    check("rst_wr", 64'(wr_cnt), 64'd0);
    check("rst_rd", 64'(rd_cnt), 64'd0);
    rstn = 1'b1;
    step();

    // 1: full write then read back, zero latency
    do_req(1, 0, 32'h4000_0008, 64'h1122_3344_5566_7788, 8'hFF, 0);
    check("w1_ack", 64'(ack), 64'd1);
    check("w1_err", 64'(err), 64'd0);
    check("w1_wr", 64'(wr_cnt), 64'd1);
    step();
    check("w1_ack_1cyc", 64'(ack), 64'd0);
    do_req(0, 1, 32'h4000_0008, 64'd0, 8'h00, 0);
    check("r1_ack", 64'(ack), 64'd1);
    check("r1_err", 64'(err), 64'd0);
    check("r1_data", rdata, 64'h1122_3344_5566_7788);
    check("r1_rd", 64'(rd_cnt), 64'd1);
    step();
    check("r1_hold", rdata, 64'h1122_3344_5566_7788);

    // 2: partial byte-lane write
    do_req(1, 0, 32'h4000_0008, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0F, 0);
    check("w2_ack", 64'(ack), 64'd1);
    check("w2_rdata_kept", rdata, 64'h1122_3344_5566_7788);
    step();
    do_req(0, 1, 32'h4000_0008, 64'd0, 8'h00, 0);
    check("r2_data", rdata, 64'h1122_3344_BBBB_BBBB);
    check("r2_rd", 64'(rd_cnt), 64'd2);
    step();

    // 3: out-of-window read and write
    do_req(0, 1, 32'h4000_0800, 64'd0, 8'h00, 0);
    check("r3_ack", 64'(ack), 64'd1);
    check("r3_err", 64'(err), 64'd1);
    check("r3_data", rdata, 64'd0);
    check("r3_rd", 64'(rd_cnt), 64'd2);
    step();
    do_req(1, 0, 32'h3FFF_FFF8, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 0);
    check("w3_ack", 64'(ack), 64'd1);
    check("w3_err", 64'(err), 64'd1);
    check("w3_wr", 64'(wr_cnt), 64'd2);
    step();
    do_req(0, 1, 32'h4000_0008, 64'd0, 8'h00, 0);
    check("r3b_data", rdata, 64'h1122_3344_BBBB_BBBB);
    check("r3b_err", 64'(err), 64'd0);
    step();
    do_req(1, 0, 32'h4000_07FF, 64'h0123_4567_89AB_CDEF, 8'hFF, 0);
    check("wtop_err", 64'(err), 64'd0);
    step();
    do_req(0, 1, 32'h4000_07F8, 64'd0, 8'h00, 0);
    check("rtop_data", rdata, 64'h0123_4567_89AB_CDEF);
    check("rtop_rd", 64'(rd_cnt), 64'd4);
    step();

    // 4: latency; lat_i drops to 0 once WAIT is entered
    do_req(0, 1, 32'h4000_0008, 64'd0, 8'h00, 15);
    wait_ack(n);
    check("lat15_cyc", 64'(n), 64'd15);
    check("lat15_data", rdata, 64'h1122_3344_BBBB_BBBB);
    step();
    do_req(1, 0, 32'h4000_0018, 64'h5555_6666_7777_8888, 8'hFF, 3);
    wait_ack(n);
    check("lat3_cyc", 64'(n), 64'd3);
    check("lat3_wr", 64'(wr_cnt), 64'd4);
    step();
    do_req(0, 1, 32'h4000_0018, 64'd0, 8'h00, 1);
    wait_ack(n);
    check("lat1_cyc", 64'(n), 64'd1);
    check("lat1_data", rdata, 64'h5555_6666_7777_8888);
    step();
    check("pre5_proto", 64'(proto), 64'd0);

    // 5: stray strobe during WAIT, then wen+ren together
    do_req(1, 0, 32'h4000_0020, 64'hCAFE_F00D_1234_5678, 8'hFF, 5);
    acks  = 0;
    first = -1;
    for (int i = 0; i < 12; i++) begin
      if (ack) begin
        acks++;
        if (first < 0) first = i;
      end
      wen  = (i == 2);
      addr = 32'h4000_0028;
      step();
    end
    wen = 1'b0;
    check("p5_acks", 64'(acks), 64'd1);
    check("p5_first", 64'(first), 64'd5);
    check("p5_proto", 64'(proto), 64'd1);
    check("p5_wr", 64'(wr_cnt), 64'd5);
    do_req(0, 1, 32'h4000_0020, 64'd0, 8'h00, 0);
    check("p5_rdata", rdata, 64'hCAFE_F00D_1234_5678);
    step();
    do_req(1, 1, 32'h4000_0008, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0);
    check("both_ack", 64'(ack), 64'd1);
    check("both_err", 64'(err), 64'd1);
    check("both_wr", 64'(wr_cnt), 64'd5);
    check("both_rd", 64'(rd_cnt), 64'd7);
    repeat (3) step();
    check("proto_sticky", 64'(proto), 64'd1);
    do_req(0, 1, 32'h4000_0008, 64'd0, 8'h00, 0);
    check("both_nomem", rdata, 64'h1122_3344_BBBB_BBBB);
    step();

    // 6: reset aborts a pending write
    do_req(1, 0, 32'h4000_0010, 64'h0F0F_0F0F_A5A5_A5A5, 8'hFF, 0);
    step();
    do_req(1, 0, 32'h4000_0010, 64'h9999_9999_9999_9999, 8'hFF, 4);
    repeat (2) step();
    rstn = 1'b0;
    #1;
    check("r6_ack", 64'(ack), 64'd0);
    check("r6_err", 64'(err), 64'd0);
    check("r6_rdata", rdata, 64'd0);
    check("r6_proto", 64'(proto), 64'd0);
    check("r6_wr", 64'(wr_cnt), 64'd0);
    check("r6_rd", 64'(rd_cnt), 64'd0);
    repeat (2) step();
    rstn = 1'b1;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (ack) acks++;
    end
    check("r6_noack", 64'(acks), 64'd0);
    do_req(0, 1, 32'h4000_0010, 64'd0, 8'h00, 0);
    check("r6_keep", rdata, 64'h0F0F_0F0F_A5A5_A5A5);
    check("r6_rdcnt", 64'(rd_cnt), 64'd1);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sys_bus_mem_responder.md
Name: sys_bus_mem_responder

Overview:
- Synthesizable system-bus slave that sits directly downstream of the AXI3 slave bridge.
- Consumes the bridge's sys_addr/sys_wdata/sys_sel/sys_wen/sys_ren strobes.
- Produces the sys_rdata/sys_err/sys_ack response the bridge waits on.
- Provides a byte-enabled word memory with runtime-programmable ack latency, out-of-window error responses and protocol-violation detection, so the AXI bench can close the loop through the bridge.

Parameters:
- AXI_DW, 64, data width in bits; must be 32 or 64.
- AXI_AW, 32, address width.
- AXI_SW, AXI_DW/8, byte-select width.
- DEPTH, 256, memory depth in AXI_DW words; power of two.
- BASE_ADDR, 32'h4000_0000, byte address of word 0; aligned to DEPTH*AXI_SW.

Ports:
- axi_clk_i  input  1  clock
- axi_rstn_i  input  1  asynchronous active-low reset
- sys_addr_i  input  AXI_AW  byte address of request
- sys_wdata_i  input  AXI_DW  write data
- sys_sel_i  input  AXI_SW  byte lane enables for writes
- sys_wen_i  input  1  single-cycle write request strobe
- sys_ren_i  input  1  single-cycle read request strobe
- lat_i  input  4  extra wait cycles before ack; sampled at request acceptance
- sys_rdata_o  output  AXI_DW  read data, valid when sys_ack_o=1
- sys_err_o  output  1  error response, valid when sys_ack_o=1
- sys_ack_o  output  1  single-cycle response strobe
- proto_err_o  output  1  sticky protocol-violation flag
- wr_cnt_o  output  16  completed writes that were ok (err=0)
- rd_cnt_o  output  16  completed reads that were ok (err=0)

Behaviour:
Reset:
- Asynchronous assert, synchronous release.
- All outputs go to 0 and FSM goes to IDLE.
- Memory contents are not reset and are undefined after reset.
- Reset during WAIT/ACK aborts the request; a pending write is never committed.

FSM states: IDLE, WAIT, ACK.
- IDLE: on a cycle with wen|ren=1, capture addr, wdata, sel, op and lat_i.
  - lat=0: go to ACK.
  - lat>0: load the down-counter with lat and go to WAIT.
- WAIT: decrement each cycle; at count 1 go to ACK.
- ACK: sys_ack_o=1 for exactly this cycle; next state IDLE.
- Latency: request on edge N gives ack high during cycle N+1+lat. Minimum 1 cycle, maximum 16.
- Back-to-back operation: a new request is accepted in the cycle following ACK (in IDLE).

Address decode:
- Hit when BASE_ADDR <= addr < BASE_ADDR + DEPTH*AXI_SW.
- Word index = (addr - BASE_ADDR) >> log2(AXI_SW).
- Low address bits are ignored; no alignment error.

Response rules:
- Write hit: each byte lane with sel=1 is updated on the edge that raises ack. err=0. wr_cnt_o increments.
- sel=0 write is legal: no bytes change, err=0, still counted.
- Read hit: sys_rdata_o loads the memory word on the edge that raises ack. err=0. rd_cnt_o increments.
- Miss (read or write): ack with err=1. No memory update. sys_rdata_o=0. Counters unchanged.
- wen and ren both set in one cycle: accepted as a request, answered with err=1, proto_err_o set, no memory access.
- wen or ren in WAIT or ACK state: request ignored (never acked), proto_err_o set.
- proto_err_o is sticky and clears only on reset.
- sys_rdata_o holds its value between acks; a write ack does not change it.
- Counters wrap 16'hFFFF -> 0.

Decomposition:
- Package sys_bus_pkg holds:
  - state enum {IDLE, WAIT, ACK};
  - constant ADDR_LSB = $clog2(AXI_SW);
  - typedef sys_req_t {addr, wdata, sel, wen, ren, lat} for the captured request.
- Sub-module sys_bus_mem_bank holds the byte-enabled single-port RAM:
  - ports: clk, we, sel, idx, wdata, rdata;
  - one-cycle read latency;
  - inferred as block RAM.

Test Plan (AXI_DW=64, DEPTH=256, BASE_ADDR=0x4000_0000):
1. Write 0x4000_0008, data 0x1122334455667788, sel 0xFF, lat 0 -> ack exactly 1 cycle after the strobe, err=0, wr_cnt=1. Read back with lat 0 -> rdata 0x1122334455667788.
2. Write 0x4000_0008, sel 0x0F, data 0xAAAAAAAA_BBBBBBBB -> read returns 0x11223344_BBBBBBBB.
3. Read 0x4000_0800 (first byte past window) and write 0x3FFF_FFF8 -> both ack with err=1, rdata 0, counters unchanged, memory unchanged.
4. lat_i=15 on a read -> ack in cycle N+16. lat_i changed to 0 during WAIT -> ack timing unaffected.
5. Second wen during WAIT -> only one ack, proto_err_o=1 until reset. wen and ren in the same cycle -> ack with err=1, proto_err_o=1.
6. Assert axi_rstn_i low during WAIT of a write to 0x4000_0010 -> no ack, all outputs 0. After release, a prior-known value at 0x4000_0010 reads back unchanged.
